// File: rtl/vma_seq_pkg.sv
// Shared types for the VMA sequencer: operation codes, VMAX sources, FSM states
// and the registered strobe bundle driven toward the VMA board.
package vma_seq_pkg;

  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned DefaultCntW    = 8;

  typedef enum logic [2:0] {
    OpNop       = 3'd0,
    OpLoadAd    = 3'd1,
    OpLoadMagic = 3'd2,
    OpInc       = 3'd3,
    OpLoadPc    = 3'd4,
    OpRestore   = 3'd5
  } vma_op_t;

  typedef enum logic [1:0] {
    VMAX_VMA  = 2'd0,
    VMAX_PC   = 2'd1,
    VMAX_PREV = 2'd2,
    VMAX_AD   = 2'd3
  } vmax_src_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StExec  = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3,
    StFault = 3'd4
  } state_t;

  typedef struct packed {
    logic       vma_load;
    logic       vma_inc;
    logic       vma_ad;
    logic       vma_magic;
    logic [1:0] vmax_sel;
    logic       load_pc;
    logic       load_held;
    logic       sel_held;
    logic       mem_start;
    logic       busy;
  } strobes_t;

  localparam strobes_t StrobesOff = '0;

  // Strobes shown during EXEC for a given operation; unknown codes act as NOP.
  function automatic strobes_t decode_op(vma_op_t op, logic [1:0] vmax);
    strobes_t s;
    s          = StrobesOff;
    s.vmax_sel = vmax;
    case (op)
      OpLoadAd: begin
        s.vma_load = 1'b1;
        s.vma_ad   = 1'b1;
      end
      OpLoadMagic: begin
        s.vma_load  = 1'b1;
        s.vma_magic = 1'b1;
      end
      OpInc:     s.vma_inc = 1'b1;
      OpLoadPc:  s.load_pc = 1'b1;
      OpRestore: begin
        s.sel_held = 1'b1;
        s.vma_load = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vma_ref_timer.sv
// Reference watchdog: loadable up-counter with enable that stops at its terminal
// count, so it can never wrap while a reference is outstanding.
module vma_ref_timer #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TERMINAL = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TermCount = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == TermCount);

endmodule

// File: rtl/vma_seq.sv
// VMA sequencer/arbiter: grants one trap or microcode op per cycle, drives the
// registered VMA strobes and watches the resulting memory reference.
module vma_seq
  import vma_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uc_req,
  input  logic [2:0] uc_op,
  input  logic       uc_mem,
  input  logic [1:0] uc_vmax,
  input  logic       trap_req,
  input  logic       mem_done,
  input  logic       page_fail,
  output logic       uc_ack,
  output logic       trap_ack,
  output logic       vma_load,
  output logic       vma_inc,
  output logic       vma_ad,
  output logic       vma_magic,
  output logic [1:0] vmax_sel,
  output logic       load_pc,
  output logic       load_held,
  output logic       sel_held,
  output logic       mem_start,
  output logic       busy,
  output logic       timeout
);

  state_t   state_q, state_d;
  logic     mem_q, mem_d;
  logic     timeout_q, timeout_d;
  strobes_t strb_q, strb_d;
  logic     tmr_load, tmr_en, tmr_tc;

  vma_ref_timer #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val ({CNT_W{1'b0}}),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  // Strobes are computed for the state being entered so that the output flops
  // present them exactly during that state.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    timeout_d = timeout_q;
    strb_d    = StrobesOff;
    uc_ack    = 1'b0;
    trap_ack  = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!reset) begin
          if (trap_req) begin
            trap_ack = 1'b1;
            mem_d    = 1'b1;
            strb_d   = decode_op(OpLoadMagic, VMAX_VMA);
            state_d  = StExec;
          end else if (uc_req) begin
            uc_ack    = 1'b1;
            mem_d     = uc_mem;
            timeout_d = 1'b0;
            strb_d    = decode_op(vma_op_t'(uc_op), uc_vmax);
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        if (mem_q) begin
          strb_d.mem_start = 1'b1;
          strb_d.load_held = 1'b1;
          strb_d.busy      = 1'b1;
          state_d          = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        tmr_load    = 1'b1;
        strb_d.busy = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        tmr_en = 1'b1;
        if (page_fail) begin
          strb_d.sel_held = 1'b1;
          strb_d.vma_load = 1'b1;
          strb_d.busy     = 1'b1;
          state_d         = StFault;
        end else if (mem_done) begin
          state_d = StIdle;
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          strb_d.busy = 1'b1;
        end
      end
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mem_q     <= 1'b0;
      timeout_q <= 1'b0;
      strb_q    <= StrobesOff;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      timeout_q <= timeout_d;
      strb_q    <= strb_d;
    end
  end

  assign vma_load  = strb_q.vma_load;
  assign vma_inc   = strb_q.vma_inc;
  assign vma_ad    = strb_q.vma_ad;
  assign vma_magic = strb_q.vma_magic;
  assign vmax_sel  = strb_q.vmax_sel;
  assign load_pc   = strb_q.load_pc;
  assign load_held = strb_q.load_held;
  assign sel_held  = strb_q.sel_held;
  assign mem_start = strb_q.mem_start;
  assign busy      = strb_q.busy;
  assign timeout   = timeout_q;

endmodule
